branch_ctrl: RTL
================

# branch_ctrl

Sequencing controller for the execute-stage branch path. It accepts one branch or jump per handshake and drives the BEU compare unit. It resolves direction and target, checks the result against the fetch-stage prediction, and on a mispredict holds a redirect request to fetch until it is acknowledged. It sits between the ID/EX pipeline register and the fetch PC mux, and also reports link data for writeback.

## Interface
Clock: single clock; reset is asynchronous, active-low.

Parameters:
- XLEN, 32, datapath width
- BXXOP_W, 3, branch opcode width (funct3 encoding)

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  branch/jump request valid
- req_ready  out  1  controller can accept a request
- req_bxx_opcode  in  BXXOP_W  branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU encoding)
- req_is_jal  in  1  unconditional PC-relative jump
- req_is_jalr  in  1  unconditional register-indirect jump
- req_pc  in  XLEN  instruction PC
- req_src1  in  XLEN  rs1 value
- req_src2  in  XLEN  rs2 value
- req_imm  in  XLEN  sign-extended offset
- req_pred_taken  in  1  fetch prediction: taken
- req_pred_target  in  XLEN  fetch predicted target
- flush_in  in  1  kill from an older stage (trap/interrupt)
- resp_valid  out  1  one-cycle result pulse
- resp_taken  out  1  resolved direction
- resp_link  out  XLEN  req_pc + 4 (rd write data for JAL/JALR)
- resp_mispredict  out  1  prediction was wrong
- resp_misaligned  out  1  taken target has bits [1:0] != 0
- redirect_valid  out  1  fetch must restart at redirect_pc
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  XLEN  correct next PC
- flush_younger  out  1  one-cycle pulse: squash IF/ID contents

## Operation
- FSM states IDLE, RESOLVE, REDIRECT. Reset state is IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid, all req_* fields are captured into registers and the FSM moves to RESOLVE.
- RESOLVE (exactly one cycle):
  - The BEU compare unit is driven from the captured src1/src2/opcode.
  - taken = is_jal | is_jalr | beu_result.
  - Target computation:
    - JALR: target = (src1 + imm) & ~1.
    - Otherwise: target = pc + imm.
  - All adds are modulo 2^XLEN; no overflow detection.
  - mispredict = (taken != pred_taken) | (taken & pred_target != target).
  - misaligned = taken & (target[1:0] != 0).
  - resp_valid = 1 in this cycle.
  - Transition:
    - mispredict & !misaligned: go to REDIRECT, load redirect_pc = taken ? target : pc+4, and pulse flush_younger.
    - Otherwise: return to IDLE.
  - A misaligned result produces no redirect; trap handling belongs to the consumer of resp_misaligned.
- REDIRECT:
  - redirect_valid = 1; redirect_pc is held stable.
  - When redirect_ready = 1, the FSM returns to IDLE.
- flush_in:
  - In RESOLVE: resp_valid, flush_younger and the redirect are all suppressed; next state is IDLE.
  - In REDIRECT: the redirect is dropped and the next state is IDLE.
  - In IDLE: req_ready = 0 for that cycle, so nothing is accepted.
  - flush_in beats redirect_ready when both are high in the same cycle.
- Reset mid-operation returns to IDLE immediately.

## Timing
- Request handshake: accepted in cycle N when req_valid & req_ready are both high. resp_valid is high in cycle N+1.
- On mispredict:
  - flush_younger pulses in cycle N+1.
  - redirect_valid rises in cycle N+2 and stays high until the cycle in which redirect_ready is sampled high.
  - The FSM is back in IDLE in the following cycle.
- Throughput: one request per 2 cycles with no mispredict; 3 cycles plus ack wait on mispredict.
- req_ready is a function of state and flush_in only, with no path from req_valid.
- All outputs are registered or decoded from state plus captured registers.
- Reset values: req_ready=1, resp_valid=0, resp_taken=0, resp_link=0, resp_mispredict=0, resp_misaligned=0, redirect_valid=0, redirect_pc=0, flush_younger=0.

## Structure
- Shared package (core_pkg) holds:
  - The branch state enum (IDLE/RESOLVE/REDIRECT).
  - The BXXOP encodings BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - The request struct type.
- Exactly one sub-module: an instance of the existing BEU compare unit, fed from the captured operands.
- Target adder, link adder and FSM are implemented inline.

## Test plan
- BEQ: src1=5, src2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120.
  - Expect resp_valid at N+1, taken=1, mispredict=0, no redirect.
- BLT: src1=0xFFFFFFFF, src2=1, pc=0x200, imm=0x40, pred_taken=0.
  - Expect taken=1, mispredict=1, flush_younger at N+1, redirect_pc=0x240 held.
  - Hold redirect_ready=0 for 3 cycles: redirect_valid and redirect_pc must stay stable. Raise redirect_ready: IDLE next cycle.
- BGEU: src1=1, src2=0xFFFFFFFF, pc=0x300, pred_taken=1.
  - Expect taken=0, mispredict=1, redirect_pc=0x304.
- JALR: src1=0x1001, imm=0x10, pc=0x400, pred_target=0x1010.
  - Expect target 0x1010, taken=1, link=0x404, mispredict=0.
- JAL: pc=0x500, imm=0x6 (target 0x506).
  - Expect misaligned=1 and no redirect/flush_younger.
- Mispredicting BNE with flush_in asserted in RESOLVE: resp_valid=0, no flush_younger/redirect.
- Mispredicting BNE with flush_in asserted in REDIRECT, same cycle as redirect_ready: redirect dropped, IDLE next cycle.
- rst_b asserted in REDIRECT: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and encodings for the execute-stage branch path
package core_pkg;

  localparam int CORE_XLEN    = 32;
  localparam int CORE_BXXOP_W = 3;

  localparam logic [2:0] BXX_BEQ  = 3'b000;
  localparam logic [2:0] BXX_BNE  = 3'b001;
  localparam logic [2:0] BXX_BLT  = 3'b100;
  localparam logic [2:0] BXX_BGE  = 3'b101;
  localparam logic [2:0] BXX_BLTU = 3'b110;
  localparam logic [2:0] BXX_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_RESOLVE,
    BR_REDIRECT
  } br_state_e;

  typedef struct packed {
    logic [CORE_BXXOP_W-1:0] bxx_opcode;
    logic                    is_jal;
    logic                    is_jalr;
    logic [CORE_XLEN-1:0]    pc;
    logic [CORE_XLEN-1:0]    src1;
    logic [CORE_XLEN-1:0]    src2;
    logic [CORE_XLEN-1:0]    imm;
    logic                    pred_taken;
    logic [CORE_XLEN-1:0]    pred_target;
  } br_req_t;

endpackage

// File: rtl/branch_ctrl_beu.sv
// rtl/branch_ctrl_beu.sv - branch condition compare unit (BEQ/BNE/BLT/BGE/BLTU/BGEU)
module branch_ctrl_beu
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BXXOP_W = 3
) (
  input  logic [BXXOP_W-1:0] bxx_opcode,
  input  logic [XLEN-1:0]    src1,
  input  logic [XLEN-1:0]    src2,
  output logic               result
);

  always_comb begin
    result = 1'b0;
    case (bxx_opcode)
      BXX_BEQ:  result = (src1 == src2);
      BXX_BNE:  result = (src1 != src2);
      BXX_BLT:  result = ($signed(src1) <  $signed(src2));
      BXX_BGE:  result = ($signed(src1) >= $signed(src2));
      BXX_BLTU: result = (src1 <  src2);
      BXX_BGEU: result = (src1 >= src2);
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump resolve, mispredict check and fetch redirect sequencer
module branch_ctrl
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int BXXOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BXXOP_W-1:0] req_bxx_opcode,
  input  logic               req_is_jal,
  input  logic               req_is_jalr,
  input  logic [XLEN-1:0]    req_pc,
  input  logic [XLEN-1:0]    req_src1,
  input  logic [XLEN-1:0]    req_src2,
  input  logic [XLEN-1:0]    req_imm,
  input  logic               req_pred_taken,
  input  logic [XLEN-1:0]    req_pred_target,
  input  logic               flush_in,
  output logic               resp_valid,
  output logic               resp_taken,
  output logic [XLEN-1:0]    resp_link,
  output logic               resp_mispredict,
  output logic               resp_misaligned,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               flush_younger
);

  br_state_e      state;
  br_req_t        req_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            beu_result;
  logic            is_resolve;
  logic            taken_c;
  logic            mispredict_c;
  logic            misaligned_c;
  logic            redirect_c;
  logic [XLEN-1:0] sum_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] link_c;

  branch_ctrl_beu #(
    .XLEN    (XLEN),
    .BXXOP_W (BXXOP_W)
  ) u_beu (
    .bxx_opcode (req_q.bxx_opcode),
    .src1       (req_q.src1),
    .src2       (req_q.src2),
    .result     (beu_result)
  );

  // JALR bases on rs1 and clears bit 0; everything else is PC-relative.
  assign sum_c        = (req_q.is_jalr ? req_q.src1 : req_q.pc) + req_q.imm;
  assign target_c     = req_q.is_jalr ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
  assign link_c       = req_q.pc + XLEN'(4);
  assign taken_c      = req_q.is_jal | req_q.is_jalr | beu_result;
  assign mispredict_c = (taken_c != req_q.pred_taken) |
                        (taken_c & (req_q.pred_target != target_c));
  assign misaligned_c = taken_c & (target_c[1:0] != 2'b00);
  assign redirect_c   = mispredict_c & ~misaligned_c;
  assign is_resolve   = (state == BR_RESOLVE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= BR_IDLE;
      req_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state)
        BR_IDLE: begin
          if (req_valid && !flush_in) begin
            req_q <= '{bxx_opcode:  req_bxx_opcode,
                       is_jal:      req_is_jal,
                       is_jalr:     req_is_jalr,
                       pc:          req_pc,
                       src1:        req_src1,
                       src2:        req_src2,
                       imm:         req_imm,
                       pred_taken:  req_pred_taken,
                       pred_target: req_pred_target};
            state <= BR_RESOLVE;
          end
        end
        BR_RESOLVE: begin
          if (!flush_in && redirect_c) begin
            redirect_pc_q <= taken_c ? target_c : link_c;
            state         <= BR_REDIRECT;
          end else begin
            state <= BR_IDLE;
          end
        end
        BR_REDIRECT: begin
          if (flush_in || redirect_ready) state <= BR_IDLE;
        end
        default: state <= BR_IDLE;
      endcase
    end
  end

  // Response fields read as zero outside the resolve cycle.
  assign req_ready       = (state == BR_IDLE) & ~flush_in;
  assign resp_valid      = is_resolve & ~flush_in;
  assign resp_taken      = is_resolve & taken_c;
  assign resp_link       = is_resolve ? link_c : '0;
  assign resp_mispredict = is_resolve & mispredict_c;
  assign resp_misaligned = is_resolve & misaligned_c;
  assign flush_younger   = resp_valid & redirect_c;
  assign redirect_valid  = (state == BR_REDIRECT) & ~flush_in;
  assign redirect_pc     = redirect_pc_q;

endmodule
